// File: rtl/dmem_bus_master.sv
// CPU-side data-memory bus initiator: one load/store at a time over DAD/DDT/MREQ/WRITE/SIZE/ACKD_n,
// with load extension, store lane placement, error reporting and performance counters.
module dmem_bus_master #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 stall,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic [31:0]          load_cnt,
  output logic [31:0]          store_cnt,
  output logic [31:0]          wait_cnt
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state, state_d;
  logic                 req_bad, accept_ok;
  logic                 bus_ack, bus_wait, bus_tmo;
  logic                 uns_q;
  logic                 ddt_oe;
  logic [BIT_WIDTH-1:0] ddt_out;
  logic [BIT_WIDTH-1:0] lane_wdata;
  logic [BIT_WIDTH-1:0] load_data;
  logic [WAIT_W-1:0]    wait_q;

  assign DDT = ddt_oe ? ddt_out : 'z;

  // Request legality and bus-cycle events
  always_comb begin : decode
    req_bad   = (req_size == SZ_ILL)
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || ((req_size == SZ_HALF) && req_addr[0]);
    accept_ok = (state == ST_IDLE) && req_valid && !req_bad;
    bus_ack   = (state == ST_BUS) && !ACKD_n;
    bus_wait  = (state == ST_BUS) && ACKD_n;
    bus_tmo   = bus_wait && (wait_q == WAIT_LAST);
  end

  // Store data right-justified into the low lanes
  always_comb begin : store_lanes
    case (req_size)
      SZ_HALF: lane_wdata = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      SZ_BYTE: lane_wdata = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
      default: lane_wdata = req_wdata;
    endcase
  end

  // Load data extension from the low lanes of DDT
  always_comb begin : load_extend
    case (SIZE)
      SZ_HALF: load_data = {{(BIT_WIDTH-16){~uns_q & DDT[15]}}, DDT[15:0]};
      SZ_BYTE: load_data = {{(BIT_WIDTH-8){~uns_q & DDT[7]}}, DDT[7:0]};
      default: load_data = DDT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin : next_state
    state_d = state;
    case (state)
      ST_IDLE: if (req_valid) state_d = req_bad ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || bus_tmo) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline handshake: the accept cycle already holds the pipeline
  always_comb begin : hs_outputs
    req_ready = 1'b0;
    stall     = 1'b0;
    if (state == ST_IDLE) begin
      req_ready = 1'b1;
      stall     = req_valid;
    end else if (state == ST_BUS) begin
      stall     = 1'b1;
    end
  end

  // Bus-side registers; MREQ and DDT drive follow the next state so they drop on the exit edge
  always_ff @(posedge clk or negedge rst) begin : bus_regs
    if (!rst) begin
      DAD     <= '0;
      WRITE   <= 1'b0;
      SIZE    <= SZ_WORD;
      uns_q   <= 1'b0;
      ddt_out <= '0;
      ddt_oe  <= 1'b0;
      MREQ    <= 1'b0;
      wait_q  <= '0;
    end else begin
      if (accept_ok) begin
        DAD     <= req_addr;
        WRITE   <= req_write;
        SIZE    <= req_size;
        uns_q   <= req_unsigned;
        ddt_out <= lane_wdata;
        wait_q  <= '0;
      end else if (bus_wait) begin
        wait_q  <= wait_q + WAIT_W'(1);
      end
      MREQ   <= (state_d == ST_BUS);
      ddt_oe <= (state_d == ST_BUS) && (accept_ok ? req_write : WRITE);
    end
  end

  // Response registers; rdata holds between pulses
  always_ff @(posedge clk or negedge rst) begin : resp_regs
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_d == ST_RESP);
      resp_err   <= (state_d == ST_RESP) && !bus_ack;
      if (state_d == ST_RESP)
        resp_rdata <= (bus_ack && !WRITE) ? load_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : perf_cnt
    if (!rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (bus_ack && !WRITE) load_cnt  <= load_cnt + 32'd1;
      if (bus_ack && WRITE)  store_cnt <= store_cnt + 32'd1;
      if (bus_wait && (wait_cnt != 32'hFFFF_FFFF)) wait_cnt <= wait_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Self-checking bench for dmem_bus_master: directed bus scenarios plus randomized accesses
// checked against a behavioural model of loads, stores, errors and counters.
module tb_dmem_bus_master;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata, DAD;
  logic        MREQ, WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;
  wire  [31:0] DDT;
  logic [31:0] load_cnt, store_cnt, wait_cnt;

  logic        tb_oe = 1'b0;
  logic [31:0] tb_data = '0;
  assign DDT = tb_oe ? tb_data : 'z;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_load = 0, exp_store = 0, exp_wait = 0;

  dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .stall(stall), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .DDT(DDT),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  // Expected extended load value from the raw bus word
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] d);
    int unsigned v;
    case (sz)
      2'b01: begin v = d % 32'h10000; if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000; end
      2'b10: begin v = d % 32'h100;   if (!uns && v >= 32'h80)   v = v + 32'hFFFF_FF00; end
      default: v = d;
    endcase
    return v;
  endfunction

  // One complete access; entered and left in an IDLE cycle, just after the rising edge
  task automatic run_access(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] ddt_val, input int waits,
                            input string tag);
    bit          bad, tmo;
    int          nbus;
    logic [31:0] lane, exp_rd;
    bad  = (sz == 2'b11) || (sz == 2'b00 && addr % 4 != 0) || (sz == 2'b01 && addr % 2 != 0);
    tmo  = !bad && (waits >= int'(TMO));
    nbus = bad ? 0 : (tmo ? int'(TMO) : waits + 1);
    case (sz)
      2'b01:   lane = wdata % 32'h10000;
      2'b10:   lane = wdata % 32'h100;
      default: lane = wdata;
    endcase
    exp_rd = (bad || tmo || wr) ? 32'h0 : model_load(sz, uns, ddt_val);

    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL %s accept: ready=%b stall=%b, want 1/1", tag, req_ready, stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;

    for (int i = 0; i < nbus; i++) begin
      checks++;
      if (MREQ !== 1'b1 || stall !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL %s bus cycle %0d: mreq=%b stall=%b ready=%b rv=%b, want 1/1/0/0",
                           tag, i, MREQ, stall, req_ready, resp_valid);
      end
      checks++;
      if (DAD !== addr || WRITE !== wr || SIZE !== sz) begin
        errors++; $display("FAIL %s bus fields: dad=%h wr=%b size=%b, want %h/%b/%b",
                           tag, DAD, WRITE, SIZE, addr, wr, sz);
      end
      if (wr) begin
        checks++;
        if (DDT !== lane) begin
          errors++; $display("FAIL %s store lanes: ddt=%h, want %h", tag, DDT, lane);
        end
      end
      if (i < waits) begin
        ACKD_n = 1'b1;
        if (!wr) begin tb_oe = 1'b1; tb_data = $urandom; end
      end else begin
        ACKD_n = 1'b0;
        if (!wr) begin tb_oe = 1'b1; tb_data = ddt_val; end
      end
      @(posedge clk); #1;
      ACKD_n = 1'b1; tb_oe = 1'b0;
      if (i < waits) exp_wait++;
    end
    if (!bad && !tmo) begin
      if (wr) exp_store++;
      else    exp_load++;
    end

    checks++;
    if (resp_valid !== 1'b1 || resp_err !== (bad || tmo) || MREQ !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL %s resp: rv=%b err=%b mreq=%b stall=%b ready=%b, want 1/%b/0/0/0",
                         tag, resp_valid, resp_err, MREQ, stall, req_ready, bad || tmo);
    end
    checks++;
    if (resp_rdata !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h, want %h", tag, resp_rdata, exp_rd);
    end
    checks++;
    if (load_cnt !== exp_load || store_cnt !== exp_store || wait_cnt !== exp_wait) begin
      errors++; $display("FAIL %s counters: ld=%0d st=%0d wt=%0d, want %0d/%0d/%0d",
                         tag, load_cnt, store_cnt, wait_cnt, exp_load, exp_store, exp_wait);
    end
    if (wr) begin
      tb_oe = 1'b1; tb_data = 32'hA5A5_5A5A; #1;
      checks++;
      if (DDT !== 32'hA5A5_5A5A) begin
        errors++; $display("FAIL %s ddt release: got %h, want a5a55a5a", tag, DDT);
      end
      tb_oe = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || MREQ !== 1'b0 || resp_rdata !== exp_rd) begin
      errors++; $display("FAIL %s idle after resp: rv=%b ready=%b mreq=%b rdata=%h, want 0/1/0/%h",
                         tag, resp_valid, req_ready, MREQ, resp_rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (MREQ !== 1'b0 || WRITE !== 1'b0 || SIZE !== 2'b00 || DAD !== 32'h0) begin
      errors++; $display("FAIL reset bus: mreq=%b wr=%b size=%b dad=%h, want 0/0/00/0", MREQ, WRITE, SIZE, DAD);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset resp: rv=%b err=%b rdata=%h stall=%b, want 0/0/0/0",
                         resp_valid, resp_err, resp_rdata, stall);
    end
    checks++;
    if (load_cnt !== 32'h0 || store_cnt !== 32'h0 || wait_cnt !== 32'h0) begin
      errors++; $display("FAIL reset counters: %0d/%0d/%0d, want 0/0/0", load_cnt, store_cnt, wait_cnt);
    end
    tb_oe = 1'b1; tb_data = 32'h5A5A_A5A5; #1;
    checks++;
    if (DDT !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL reset ddt release: got %h, want 5a5aa5a5", DDT);
    end
    tb_oe = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset ready: got %b, want 1", req_ready);
    end
  endtask

  task automatic test_word_load();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, "word_load");
  endtask

  task automatic test_extension();
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0080, 0, "byte_signed");
    run_access(1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_0080, 1, "byte_unsigned");
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_8001, 0, "half_signed");
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 2, "half_unsigned");
  endtask

  task automatic test_stores();
    run_access(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 32'h0, 0, "byte_store_stdout");
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 3, "word_store_wait3");
    run_access(1'b1, 2'b01, 1'b0, 32'hFF00_0000, 32'h9876_ABCD, 32'h0, 1, "half_store_exit");
  endtask

  task automatic test_errors();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0, "misaligned_word");
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h1111_1111, 0, "misaligned_half");
    run_access(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h55, 32'h0, 0, "illegal_size");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_BABE, 10, "timeout_load");
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_0304, 32'h7777_7777, 32'h0, int'(TMO), "timeout_store");
  endtask

  // ACKD_n pulled low while no bus cycle is open must have no effect
  task automatic test_idle_ack();
    ACKD_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (MREQ !== 1'b0 || resp_valid !== 1'b0 || load_cnt !== exp_load || store_cnt !== exp_store
          || wait_cnt !== exp_wait) begin
        errors++; $display("FAIL idle_ack %0d: mreq=%b rv=%b ld=%0d st=%0d wt=%0d", i, MREQ, resp_valid,
                           load_cnt, store_cnt, wait_cnt);
      end
    end
    ACKD_n = 1'b1;
  endtask

  // Request held valid across two accesses with immediate acknowledge
  task automatic test_back_to_back();
    logic [4:0]  exp_mreq, exp_rv, exp_rdy;
    logic [31:0] exp_dad;
    exp_mreq = 5'b01001;  // bit i = cycle i after the first accept edge
    exp_rv   = 5'b10010;
    exp_rdy  = 5'b00100;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h40; ACKD_n = 1'b0; tb_oe = 1'b1; tb_data = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_dad = (i < 3) ? 32'h40 : 32'h44;
      checks++;
      if (MREQ !== exp_mreq[i] || resp_valid !== exp_rv[i] || req_ready !== exp_rdy[i] || DAD !== exp_dad) begin
        errors++; $display("FAIL b2b cycle %0d: mreq=%b rv=%b ready=%b dad=%h, want %b/%b/%b/%h", i, MREQ,
                           resp_valid, req_ready, DAD, exp_mreq[i], exp_rv[i], exp_rdy[i], exp_dad);
      end
      if (i == 1 || i == 4) begin
        checks++;
        if (resp_rdata !== ((i == 1) ? 32'h1111_1111 : 32'h2222_2222)) begin
          errors++; $display("FAIL b2b rdata %0d: got %h", i, resp_rdata);
        end
      end
      if (i == 2) begin req_addr = 32'h44; tb_data = 32'h2222_2222; end
      if (i == 4) begin req_valid = 1'b0; ACKD_n = 1'b1; tb_oe = 1'b0; end
    end
    exp_load += 2;
    @(posedge clk); #1;
    checks++;
    if (load_cnt !== exp_load || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b end: ld=%0d ready=%b, want %0d/1", load_cnt, req_ready, exp_load);
    end
  endtask

  task automatic test_random();
    bit          wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % 4);
      run_access(wr, sz, uns, addr, $urandom, $urandom, int'($urandom_range(0, 5)), "random");
    end
  endtask

  // Asynchronous reset in the middle of a store bus cycle
  task automatic test_reset_mid_bus();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h200; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (MREQ !== 1'b1 || DDT !== 32'h1234_5678) begin
      errors++; $display("FAIL rst_mid setup: mreq=%b ddt=%h, want 1/12345678", MREQ, DDT);
    end
    #2; rst = 1'b0; #1;
    exp_load = 0; exp_store = 0; exp_wait = 0;
    checks++;
    if (MREQ !== 1'b0 || resp_valid !== 1'b0 || load_cnt !== 32'h0 || store_cnt !== 32'h0 || wait_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_mid drop: mreq=%b rv=%b ld=%0d st=%0d wt=%0d, want 0/0/0/0/0",
                         MREQ, resp_valid, load_cnt, store_cnt, wait_cnt);
    end
    tb_oe = 1'b1; tb_data = 32'hA5A5_5A5A; #1;
    checks++;
    if (DDT !== 32'hA5A5_5A5A) begin
      errors++; $display("FAIL rst_mid ddt release: got %h, want a5a55a5a", DDT);
    end
    tb_oe = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || MREQ !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
        errors++; $display("FAIL rst_mid after %0d: rv=%b mreq=%b ready=%b rdata=%h, want 0/0/1/0",
                           i, resp_valid, MREQ, req_ready, resp_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_extension();
    test_stores();
    test_errors();
    test_timeout();
    test_idle_ack();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_bus_master.md
Name: dmem_bus_master

Overview:
- CPU-side initiator for the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n), instantiated inside top.
- Accepts one load/store request at a time from the MEM stage, runs the bus handshake and stalls the pipeline until ACKD_n.
- Aligns and sign-extends load data and places store data in the lanes the memory model expects.
- Provides misalignment and timeout error reporting plus access/wait performance counters.

Parameters:
- BIT_WIDTH, 32, address/data width
- TIMEOUT, 255, maximum wait cycles for ACKD_n before abort (1..65535)

Ports:
- clk  in  1  clock, all flops rise-edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM-stage access request
- req_ready  out  1  high when a request can be accepted (IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=word, 01=half, 10=byte, 11=illegal
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or timeout
- resp_rdata  out  32  extended load data, valid with resp_valid
- stall  out  1  pipeline hold: request accepted and not yet completed
- DAD  out  32  bus address
- MREQ  out  1  bus request
- WRITE  out  1  bus direction
- SIZE  out  2  bus size, same encoding as req_size
- ACKD_n  in  1  bus acknowledge, active-low
- DDT  inout  32  bus data, driven only during store cycles
- load_cnt, store_cnt  out  32  completed bus loads/stores, wrapping
- wait_cnt  out  32  cycles with MREQ=1 and ACKD_n=1, saturating at 0xFFFFFFFF

Behaviour:
- Reset (async, rst=0):
  - MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT released (Z).
  - resp_valid=0, resp_err=0, resp_rdata=0, stall=0.
  - All counters 0; state=IDLE.
  - Reset mid-cycle drops MREQ and DDT drive immediately, with no response pulse.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - Edge with req_valid=1, legal and aligned request: register DAD, WRITE, SIZE, and store lane data; go to BUS.
  - Edge with req_valid=1, misaligned or illegal: go to RESP with the error flag set; no bus cycle.
  - Misaligned means word with addr[1:0]!=0, or half with addr[0]!=0. Illegal means size 11.
- BUS:
  - MREQ=1, stall=1, req_ready=0.
  - If WRITE=1, DDT is driven with: word = wdata; half = {16'b0, wdata[15:0]}; byte = {24'b0, wdata[7:0]}.
  - Edge sampling ACKD_n=0:
    - Capture DDT.
    - Load data: word = as-is; half = DDT[15:0] extended; byte = DDT[7:0] extended, per req_unsigned.
    - Increment load_cnt or store_cnt; go to RESP.
  - Edge sampling ACKD_n=1: increment wait and wait_cnt.
  - Timeout: when wait reaches TIMEOUT, go to RESP with resp_err=1 and rdata=0; no load/store count.
  - Any state change out of BUS releases MREQ and DDT on the same edge.
- RESP (one cycle):
  - resp_valid=1 with resp_err/resp_rdata; stall=0; MREQ=0.
  - Next state is IDLE; req_ready=0 during RESP.
  - Store resp_rdata=0.
- Latency: accept at edge k; MREQ high from k. With ACKD_n low at edge k+1, resp_valid is high in the cycle after edge k+1. Minimum 2 cycles accept to response; a new request can be accepted at edge k+3.
- stall = (state==BUS) | (IDLE & req_valid) so the pipeline holds in the accept cycle.
- Addresses pass unmodified, including STDOUT 0xF0000000 and EXIT 0xFF000000; no special handling.
- ACKD_n low while MREQ=0 is ignored.
- resp_rdata holds its last value between pulses.

Test Plan:
- Word load: req addr 0x100, memory 0xDEADBEEF, ACKD_n low the first cycle -> MREQ=1/WRITE=0/SIZE=00/DAD=0x100 for 1 cycle; resp_valid 2 cycles after accept, rdata=0xDEADBEEF; load_cnt=1.
- Byte/half extension: byte load at 0x103 with DDT=0x00000080, req_unsigned=0 -> rdata=0xFFFFFF80; with req_unsigned=1 -> 0x00000080. Half load with DDT=0x00008001, signed -> 0xFFFF8001.
- Stores and latency:
  - Byte store 0x41 to 0xF0000000 -> DDT=0x00000041, SIZE=10, WRITE=1.
  - Word store with ACKD_n held high 3 cycles -> MREQ high 4 cycles, wait_cnt=3, store_cnt=1, stall high throughout.
- Errors:
  - Word load at 0x102 -> no MREQ; resp_valid and resp_err=1 next cycle.
  - req_size=11 -> same response.
  - TIMEOUT=4 with no ACK -> MREQ drops after 4 wait cycles; resp_err=1, rdata=0.
- Back-to-back and reset:
  - Two queued loads -> second accepted in the cycle after the first RESP; no overlapping MREQ.
  - rst low while in BUS -> MREQ=0 and DDT=Z immediately, counters 0, no resp_valid after release.
